// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and width helpers for the reset sequencer.
// Optional timeout support is enabled with RESET_SEQUENCER_TIMEOUT_EN.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_DONE       = 2'd2
  } state_t;

  // Bits needed to hold the values 0..count-1, never less than one.
  function automatic int bits_for(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_counter.sv
// Clearable up-counter with a compare against a run-time terminal value.
// Shared by the hold and timeout phases of the reset sequencer.
module sequencer_counter
  import reset_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time after a hold period and ready handshake.
// Define RESET_SEQUENCER_TIMEOUT_EN to bound the ready wait and expose timeout_error.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGE_COUNT    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STAGE_COUNT-1:0] stage_ready,
  output logic [STAGE_COUNT-1:0] reset_out,
  output logic                   sequence_done
`ifdef RESET_SEQUENCER_TIMEOUT_EN
  ,
  output logic                   timeout_error
`endif
);

  localparam int CW = bits_for(max_int(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int IW = bits_for(STAGE_COUNT);
  localparam logic [CW-1:0] HOLD_TERM  = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(STAGE_COUNT - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   index_reg, index_next;
  logic            done_reg, done_next;
  logic            release_now;
  logic            advance;
  logic            ready_now;
  logic            count_clear;
  logic            count_enable;
  logic [CW-1:0]   count_terminal;
  logic [CW-1:0]   count_value;
  logic            at_terminal;

  sequencer_counter #(
    .WIDTH(CW)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (count_clear),
    .enable     (count_enable),
    .terminal   (count_terminal),
    .count      (count_value),
    .at_terminal(at_terminal)
  );

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_TERM = CW'(TIMEOUT_CYCLES - 1);
  logic timeout_reg, timeout_set;

  assign count_terminal = (state_reg == ST_HOLD) ? HOLD_TERM : TIMEOUT_TERM;
  assign timeout_error  = timeout_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_reg <= 1'b0;
    end else if (timeout_set) begin
      timeout_reg <= 1'b1;
    end
  end
`else
  assign count_terminal = HOLD_TERM;
`endif

  // Only the stage currently being sequenced is looked at; other ready bits are don't-care.
  assign ready_now = stage_ready[index_reg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_HOLD;
      index_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    done_next    = done_reg;
    release_now  = 1'b0;
    advance      = 1'b0;
    count_clear  = 1'b0;
    count_enable = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    timeout_set  = 1'b0;
`endif
    case (state_reg)
      ST_HOLD: begin
        count_enable = 1'b1;
        if (at_terminal) begin
          release_now = 1'b1;
          count_clear = 1'b1;
          state_next  = ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        count_enable = 1'b1;
        // A ready arriving on the timeout edge wins, so no error is flagged.
        if (ready_now) begin
          advance = 1'b1;
        end else if (at_terminal) begin
          advance     = 1'b1;
          timeout_set = 1'b1;
        end
`else
        advance = ready_now;
`endif
        if (advance) begin
          count_clear = 1'b1;
          if (index_reg == LAST_INDEX) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            index_next = index_reg + IW'(1);
            state_next = ST_HOLD;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  assign sequence_done = done_reg;

  // One flop per stage; a bit can only ever be cleared, so releases never re-assert.
  genvar gi;
  generate
    for (gi = 0; gi < STAGE_COUNT; gi++) begin : g_stage
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          reset_out[gi] <= 1'b1;
        end else if (release_now && (index_reg == IW'(gi))) begin
          reset_out[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: table of directed scenarios plus random ready traffic
// checked against an event-schedule model. Honours RESET_SEQUENCER_TIMEOUT_EN when defined.
module tb_reset_sequencer;

  localparam int N     = 4;
  localparam int H     = 3;
  localparam int T     = 5;
  localparam int MAXE  = 200;
  localparam int NEVER = 1000000;

  logic         clock;
  logic         reset;
  logic [N-1:0] stage_ready;
  logic [N-1:0] reset_out;
  logic         sequence_done;
  logic         timeout_obs;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] ready_seq [1:MAXE];
  int obs_fall [N];
  int obs_done;
  int obs_to;
  int exp_rel [N];
  int exp_done;
  int exp_to;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic timeout_error;
  assign timeout_obs = timeout_error;
`else
  assign timeout_obs = 1'b0;
`endif

  reset_sequencer #(
    .STAGE_COUNT   (N),
    .HOLD_CYCLES   (H),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stage_ready  (stage_ready),
    .reset_out    (reset_out),
    .sequence_done(sequence_done)
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    ,
    .timeout_error(timeout_error)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reset is raised and then dropped on a falling edge, so the next rising edge is edge 1.
  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Model: each stage releases HOLD edges after the previous acknowledge; the acknowledge is
  // the first later edge where that stage's ready is sampled high (or the timeout edge).
  task automatic compute_schedule();
    int r;
    int ack;
    r        = H;
    exp_done = NEVER;
    exp_to   = NEVER;
    for (int i = 0; i < N; i++) begin
      exp_rel[i] = r;
      ack = NEVER;
      for (int e = r + 1; e <= MAXE && ack == NEVER; e++) begin
        if (ready_seq[e][i]) begin
          ack = e;
        end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        else if (e == r + T) begin
          ack = e;
          if (exp_to == NEVER) exp_to = e;
        end
`endif
      end
      if (i == N - 1) exp_done = ack;
      r = (ack == NEVER) ? NEVER : ack + H;
    end
  endtask

  task automatic observe(input int n, input bit use_model);
    logic [N-1:0] prev;
    logic [N-1:0] exp_out;
    bit reassert;
    prev     = '1;
    reassert = 1'b0;
    for (int i = 0; i < N; i++) obs_fall[i] = NEVER;
    obs_done = NEVER;
    obs_to   = NEVER;
    for (int e = 1; e <= n; e++) begin
      stage_ready = ready_seq[e];
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (prev[i] && !reset_out[i] && obs_fall[i] == NEVER) obs_fall[i] = e;
        if (!prev[i] && reset_out[i]) reassert = 1'b1;
      end
      if (sequence_done && obs_done == NEVER) obs_done = e;
      if (timeout_obs && obs_to == NEVER) obs_to = e;
      if (use_model) begin
        for (int i = 0; i < N; i++) exp_out[i] = (e < exp_rel[i]);
        check_int($sformatf("model_reset_out_e%0d", e), int'(reset_out), int'(exp_out));
        check_int($sformatf("model_done_e%0d", e), int'(sequence_done), int'(e >= exp_done));
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        check_int($sformatf("model_timeout_e%0d", e), int'(timeout_obs), int'(e >= exp_to));
`endif
      end
      prev = reset_out;
    end
    check_int("no_reassert", int'(reassert), 0);
  endtask

  typedef struct {
    logic [N-1:0] ready_base;
    int           low_stage;
    int           low_until;
    int           rel0, rel1, rel2, rel3;
    int           done_edge;
    int           to_edge;
  } vec_t;

  vec_t vecs [4];

  initial begin
    reset       = 1'b1;
    stage_ready = '0;

    vecs[0] = '{4'b1111, -1, 0, 3, 7, 11, 15, 16, NEVER};
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    vecs[1] = '{4'b1111, 1, 20, 3, 7, 15, 19, 20, 12};
    vecs[2] = '{4'b1110, -1, 0, 3, 11, 15, 19, 20, 8};
    vecs[3] = '{4'b0000, -1, 0, 3, 11, 19, 27, 32, 8};
`else
    vecs[1] = '{4'b1111, 1, 20, 3, 7, 24, 28, 29, NEVER};
    vecs[2] = '{4'b1110, -1, 0, 3, NEVER, NEVER, NEVER, NEVER, NEVER};
    vecs[3] = '{4'b0000, -1, 0, 3, NEVER, NEVER, NEVER, NEVER, NEVER};
`endif

    repeat (3) @(negedge clock);
    check_int("reset_state_out", int'(reset_out), 15);
    check_int("reset_state_done", int'(sequence_done), 0);
    check_int("reset_state_timeout", int'(timeout_obs), 0);

    for (int v = 0; v < 4; v++) begin
      logic [N-1:0] val;
      for (int e = 1; e <= MAXE; e++) begin
        val = vecs[v].ready_base;
        if (vecs[v].low_stage >= 0 && e <= vecs[v].low_until) val[vecs[v].low_stage] = 1'b0;
        ready_seq[e] = val;
      end
      pulse_reset();
      observe(40, 1'b0);
      $display("vector %0d: falls %0d %0d %0d %0d done %0d timeout %0d",
               v, obs_fall[0], obs_fall[1], obs_fall[2], obs_fall[3], obs_done, obs_to);
      check_int($sformatf("v%0d_fall0", v), obs_fall[0], vecs[v].rel0);
      check_int($sformatf("v%0d_fall1", v), obs_fall[1], vecs[v].rel1);
      check_int($sformatf("v%0d_fall2", v), obs_fall[2], vecs[v].rel2);
      check_int($sformatf("v%0d_fall3", v), obs_fall[3], vecs[v].rel3);
      check_int($sformatf("v%0d_done", v), obs_done, vecs[v].done_edge);
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      check_int($sformatf("v%0d_timeout", v), obs_to, vecs[v].to_edge);
`endif
      if (v == 0) begin
        // Sequence complete: random ready activity must not disturb the outputs.
        for (int k = 0; k < 30; k++) begin
          stage_ready = N'($urandom);
          @(posedge clock);
          #1;
          check_int($sformatf("done_hold_out_%0d", k), int'(reset_out), 0);
          check_int($sformatf("done_hold_done_%0d", k), int'(sequence_done), 1);
        end
        $display("vector 0: done state held across random ready toggles");
      end
    end

    // Reset dropped in mid-sequence, then the sequence restarts from stage 0.
    for (int e = 1; e <= MAXE; e++) ready_seq[e] = 4'b1111;
    pulse_reset();
    observe(9, 1'b0);
    reset = 1'b1;
    #1;
    check_int("midreset_out", int'(reset_out), 15);
    check_int("midreset_done", int'(sequence_done), 0);
    @(negedge clock);
    reset = 1'b0;
    observe(20, 1'b0);
    $display("mid-sequence reset: restart falls %0d %0d done %0d", obs_fall[0], obs_fall[1], obs_done);
    check_int("midreset_refall0", obs_fall[0], 3);
    check_int("midreset_refall1", obs_fall[1], 7);
    check_int("midreset_redone", obs_done, 16);

    // Random ready traffic against the schedule model.
    for (int run = 0; run < 3; run++) begin
      for (int e = 1; e <= MAXE; e++) begin
        for (int i = 0; i < N; i++) ready_seq[e][i] = ($urandom_range(0, 2) == 0);
      end
      compute_schedule();
      pulse_reset();
      observe(150, 1'b1);
      $display("random run %0d: model releases %0d %0d %0d %0d done %0d timeout %0d",
               run, exp_rel[0], exp_rel[1], exp_rel[2], exp_rel[3], exp_done, exp_to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
